// File: rtl/mult_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the serial multiplier sequencer.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_MSTART  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_LOAD    = 3'd4,
        ST_OUTPUT  = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    // Spare top bit keeps the terminal compare clear of any wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Moore sequencer for SIPO -> multiplier -> PISO, with its own bit counting,
// multiplier watchdog, abort and optional back-to-back restart.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int IN_BITS      = 2 * WIDTH,
    parameter int OUT_BITS     = 2 * WIDTH,
    parameter int MULT_TIMEOUT = 16,
    parameter int AUTO_RESTART = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       sipo_valid,
    input  logic       mult_done,
    output logic       sipo_enable,
    output logic       mult_start,
    output logic       mult_enable,
    output logic       piso_load,
    output logic       piso_enable,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] state_o
);

    localparam int CW = cnt_width(IN_BITS, OUT_BITS, MULT_TIMEOUT);
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_BITS - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BITS - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(MULT_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inc;

    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE:    if (start && !abort) state_d = ST_RECEIVE;
            ST_RECEIVE: begin
                if (sipo_valid) begin
                    if (cnt_q == IN_LAST) state_d = ST_MSTART;
                    else                  inc     = 1'b1;
                end
            end
            ST_MSTART:  state_d = ST_COMPUTE;
            // mult_done beats the watchdog when both land on the last cycle.
            ST_COMPUTE: begin
                if (mult_done)              state_d = ST_LOAD;
                else if (cnt_q == TO_LAST)  state_d = ST_ERROR;
                else                        inc     = 1'b1;
            end
            ST_LOAD:    state_d = ST_OUTPUT;
            ST_OUTPUT: begin
                if (cnt_q == OUT_LAST) state_d = ST_DONE;
                else                   inc     = 1'b1;
            end
            ST_DONE:    state_d = (AUTO_RESTART != 0 && start) ? ST_RECEIVE : ST_IDLE;
            ST_ERROR:   if (start) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE && state_q != ST_ERROR) state_d = ST_IDLE;

        // Every state entry restarts the shared counter.
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(inc);
    end

    // Outputs are registered from the next state, so they always equal a decode of state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sipo_enable <= 1'b0;
            mult_start  <= 1'b0;
            mult_enable <= 1'b0;
            piso_load   <= 1'b0;
            piso_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            state_o     <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sipo_enable <= (state_d == ST_RECEIVE);
            mult_start  <= (state_d == ST_MSTART);
            mult_enable <= (state_d == ST_COMPUTE);
            piso_load   <= (state_d == ST_LOAD);
            piso_enable <= (state_d == ST_OUTPUT);
            busy        <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
            done        <= (state_d == ST_DONE);
            error       <= (state_d == ST_ERROR);
            state_o     <= state_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: two instances (AUTO_RESTART 0 and 1) share stimulus;
// expected states are queued per driven cycle and compared one edge later.
module tb_mult_seq_ctrl;

    localparam int NB = 8;
    localparam int TO = 16;

    localparam logic [2:0] S_IDLE = 3'd0, S_RX = 3'd1, S_MS = 3'd2, S_CP = 3'd3;
    localparam logic [2:0] S_LD = 3'd4, S_OUT = 3'd5, S_DN = 3'd6, S_ERR = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, start = 1'b0, abort = 1'b0, sipo_valid = 1'b0, mult_done = 1'b0;
    logic [1:0] sipo_enable, mult_start, mult_enable, piso_load, piso_enable, busy, done, error;
    logic [2:0] state_o [2];

    mult_seq_ctrl #(.WIDTH(4), .IN_BITS(NB), .OUT_BITS(NB), .MULT_TIMEOUT(TO), .AUTO_RESTART(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .sipo_valid(sipo_valid),
        .mult_done(mult_done), .sipo_enable(sipo_enable[0]), .mult_start(mult_start[0]),
        .mult_enable(mult_enable[0]), .piso_load(piso_load[0]), .piso_enable(piso_enable[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .state_o(state_o[0]));

    mult_seq_ctrl #(.WIDTH(4), .IN_BITS(NB), .OUT_BITS(NB), .MULT_TIMEOUT(TO), .AUTO_RESTART(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .sipo_valid(sipo_valid),
        .mult_done(mult_done), .sipo_enable(sipo_enable[1]), .mult_start(mult_start[1]),
        .mult_enable(mult_enable[1]), .piso_load(piso_load[1]), .piso_enable(piso_enable[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .state_o(state_o[1]));

    typedef struct {
        logic [2:0] e0;
        logic [2:0] e1;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Output table of the controller: {state, sipo_en, mstart, menable, pload, penable, busy, done, error}.
    function automatic logic [10:0] expect_vec(input logic [2:0] s);
        return {s, s == S_RX, s == S_MS, s == S_CP, s == S_LD, s == S_OUT,
                (s != S_IDLE) && (s != S_ERR), s == S_DN, s == S_ERR};
    endfunction

    function automatic logic [10:0] observed(input int k);
        return {state_o[k], sipo_enable[k], mult_start[k], mult_enable[k], piso_load[k],
                piso_enable[k], busy[k], done[k], error[k]};
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({"ar0 ", e.tag}, observed(0), expect_vec(e.e0));
            check({"ar1 ", e.tag}, observed(1), expect_vec(e.e1));
        end
    end

    task automatic step2(input logic st, input logic ab, input logic sv, input logic md,
                         input logic rs, input logic [2:0] e0, input logic [2:0] e1,
                         input string tag);
        exp_t e;
        @(negedge clk);
        start = st; abort = ab; sipo_valid = sv; mult_done = md; reset = rs;
        e.e0 = e0; e.e1 = e1; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input logic st, input logic ab, input logic sv, input logic md,
                        input logic rs, input logic [2:0] e, input string tag);
        step2(st, ab, sv, md, rs, e, e, tag);
    endtask

    // start, then NB strobes (optionally gapped), then the MSTART cycle.
    task automatic rx(input bit gap, input string tag);
        step(1, 0, 0, 0, 0, S_RX, {tag, " start"});
        for (int i = 0; i < NB; i++) begin
            if (gap) step(0, 0, 0, 0, 0, S_RX, {tag, " gap"});
            step(0, 0, 1, 0, 0, (i == NB - 1) ? S_MS : S_RX, {tag, " rx"});
        end
        step(0, 0, 0, 0, 0, S_CP, {tag, " mstart"});
    endtask

    // mult_done on COMPUTE cycle md_at (1-based); 0 means never.
    task automatic compute(input int md_at, input string tag);
        for (int i = 1; i <= TO; i++) begin
            if (i == md_at) begin
                step(0, 0, 0, 1, 0, S_LD, {tag, " mdone"});
                return;
            end
            step(0, 0, 0, 0, 0, (i == TO) ? S_ERR : S_CP, {tag, " compute"});
        end
    endtask

    task automatic outp(input logic hold_start, input string tag);
        step(0, 0, 0, 0, 0, S_OUT, {tag, " load"});
        for (int i = 0; i < NB; i++)
            step((i == NB - 1) ? hold_start : 1'b0, 0, 0, 0, 0,
                 (i == NB - 1) ? S_DN : S_OUT, {tag, " out"});
        step2(hold_start, 0, 0, 0, 0, S_IDLE, hold_start ? S_RX : S_IDLE, {tag, " done"});
    endtask

    initial begin
        step(0, 0, 0, 0, 1, S_IDLE, "reset");
        step(0, 0, 0, 0, 1, S_IDLE, "reset");
        step(0, 0, 0, 0, 0, S_IDLE, "idle");

        rx(0, "nominal"); compute(3, "nominal"); outp(0, "nominal");
        step(0, 0, 0, 0, 0, S_IDLE, "nominal idle");

        rx(1, "gapped"); compute(2, "gapped"); outp(0, "gapped");

        rx(0, "timeout"); compute(0, "timeout");
        step(0, 0, 0, 0, 0, S_ERR, "err sticky");
        step(0, 1, 0, 0, 0, S_ERR, "err abort ignored");
        step(1, 0, 0, 0, 0, S_IDLE, "err clear");

        rx(0, "abort"); compute(1, "abort");
        step(0, 0, 0, 0, 0, S_OUT, "abort load");
        step(0, 0, 0, 0, 0, S_OUT, "abort out1");
        step(0, 0, 0, 0, 0, S_OUT, "abort out2");
        step(0, 1, 0, 0, 0, S_IDLE, "abort out3");
        step(0, 0, 0, 0, 0, S_IDLE, "abort idle");
        rx(0, "rerun"); compute(4, "rerun"); outp(0, "rerun");

        step(1, 1, 0, 0, 0, S_IDLE, "idle start+abort");

        rx(0, "autorestart"); compute(3, "autorestart"); outp(1, "autorestart");
        step2(0, 0, 0, 0, 0, S_IDLE, S_RX, "autorestart hold");
        step(0, 0, 0, 0, 1, S_IDLE, "reset in rx");

        rx(0, "rst compute");
        step(0, 0, 0, 0, 0, S_CP, "rst compute c1");
        step(0, 0, 0, 0, 0, S_CP, "rst compute c2");
        step(0, 0, 0, 1, 1, S_IDLE, "rst compute hit");
        step(0, 0, 0, 0, 0, S_IDLE, "rst compute after");

        rx(0, "edge timeout"); compute(TO, "edge timeout"); outp(0, "edge timeout");

        repeat (3) @(negedge clk);
        check("scoreboard drained", 11'(sb.size()), 11'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
